// File: rtl/mem_pkg.sv
// Shared memory-side types: size encodings and the store buffer entry layout.
package mem_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      maskmode;
    logic            valid;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Pipeline/memory bundle around the store buffer. The buffer is the slave.
interface store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
);
  logic                  st_valid;
  logic                  st_ready;
  logic [DATA_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [1:0]            st_maskmode;
  logic                  ld_req;
  logic [DATA_WIDTH-1:0] ld_addr;
  logic [1:0]            ld_maskmode;
  logic                  ld_stall;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [1:0]            mem_maskmode;
  logic                  sb_empty;
  logic [PTR_W:0]        sb_count;

  modport slave (
    input  st_valid, st_addr, st_data, st_maskmode, ld_req, ld_addr, ld_maskmode,
    output st_ready, ld_stall, mem_read, mem_write, mem_address, mem_write_data,
           mem_maskmode, sb_empty, sb_count
  );

  modport master (
    output st_valid, st_addr, st_data, st_maskmode, ld_req, ld_addr, ld_maskmode,
    input  st_ready, ld_stall, mem_read, mem_write, mem_address, mem_write_data,
           mem_maskmode, sb_empty, sb_count
  );
endinterface

// File: rtl/store_buffer_match.sv
// Word-granular load address compare against every buffered entry.
module store_buffer_match #(
  parameter int DEPTH = 4,
  parameter int WW    = 30
) (
  input  logic [DEPTH-1:0][WW-1:0] entry_word,
  input  logic [DEPTH-1:0]         entry_valid,
  input  logic [WW-1:0]            ld_word,
  output logic                     hit
);
  logic [DEPTH-1:0] match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign match[g] = entry_valid[g] && (entry_word[g] == ld_word);
  end

  assign hit = |match;
endmodule

// File: rtl/store_buffer.sv
// Store FIFO in front of data memory; loads own the port unless they hit a
// buffered word, in which case the load stalls and the buffer drains instead.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  store_buffer_if.slave bus
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  sb_entry_t [DEPTH-1:0]               entries;
  logic [PTR_W-1:0]                    wr_ptr, rd_ptr;
  logic [PTR_W:0]                      count;
  logic [DEPTH-1:0][DATA_WIDTH-3:0]    entry_word;
  logic [DEPTH-1:0]                    entry_valid;
  logic                                hit, hazard, drain, push;
  sb_entry_t                           head;

  // Flatten entries into the compare inputs
  always_comb begin
    entry_word  = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_word[i]  = entries[i].addr[DATA_WIDTH-1:2];
      entry_valid[i] = entries[i].valid;
    end
  end

  store_buffer_match #(.DEPTH(DEPTH), .WW(DATA_WIDTH-2)) u_match (
    .entry_word  (entry_word),
    .entry_valid (entry_valid),
    .ld_word     (bus.ld_addr[DATA_WIDTH-1:2]),
    .hit         (hit)
  );

  // Port arbitration: a load wins unless it hazards; a hazarding load lets
  // the buffer drain, so a stalled load can never deadlock the FIFO.
  always_comb begin
    head   = entries[rd_ptr];
    hazard = bus.ld_req && hit;
    drain  = (count != '0) && (!bus.ld_req || hazard);
    push   = bus.st_valid && bus.st_ready;

    bus.st_ready       = (count < FULL);
    bus.ld_stall       = hazard;
    bus.mem_read       = bus.ld_req && !hazard;
    bus.mem_write      = drain;
    bus.mem_address    = drain ? head.addr : bus.ld_addr;
    bus.mem_maskmode   = drain ? head.maskmode : bus.ld_maskmode;
    bus.mem_write_data = head.data;
    bus.sb_empty       = (count == '0);
    bus.sb_count       = count;
  end

  // FIFO state; entry payload is left unreset, only valid bits clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      if (drain) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        entries[wr_ptr] <= '{addr: bus.st_addr, data: bus.st_data,
                             maskmode: bus.st_maskmode, valid: 1'b1};
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard of expected drains plus a
// small byte-lane memory model fed by the memory port.
module tb_store_buffer;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DATA_WIDTH(32), .DEPTH(4)) sb();

  store_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  mask;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [int];
  int          errors  = 0;
  int          checks  = 0;
  int          wr_disc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input int w);
    if (mem.exists(w)) return mem[w];
    return 32'h0;
  endfunction

  // Scoreboard and memory model: the write commits at the falling edge
  always @(negedge clk) begin
    if (sb.mem_write && (sb.mem_address inside {32'h300, 32'h304, 32'h308}))
      wr_disc++;
    if (!rst && sb.mem_write) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: got addr %h expected no write", sb.mem_address);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("drain_addr", sb.mem_address, e.addr);
        chk("drain_data", sb.mem_write_data, e.data);
        chk("drain_mask", {30'd0, sb.mem_maskmode}, {30'd0, e.mask});
      end
      begin
        int          w;
        logic [31:0] v;
        w = int'(sb.mem_address >> 2);
        v = rd_mem(w);
        case (sb.mem_maskmode)
          MASK_BYTE: v[sb.mem_address[1:0]*8 +: 8]  = sb.mem_write_data[7:0];
          MASK_HALF: v[sb.mem_address[1]*16 +: 16]  = sb.mem_write_data[15:0];
          MASK_WORD: v                              = sb.mem_write_data;
          default:   ;
        endcase
        mem[w] = v;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one store for one cycle; record it if the buffer takes it
  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] m, output bit acc);
    sb.st_valid    = 1'b1;
    sb.st_addr     = a;
    sb.st_data     = d;
    sb.st_maskmode = m;
    @(negedge clk);
    acc = sb.st_ready;
    if (acc) q.push_back('{a, d, m});
    @(posedge clk);
    #1;
    sb.st_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    sb.st_valid = 0; sb.st_addr = 0; sb.st_data = 0; sb.st_maskmode = 0;
    sb.ld_req = 0; sb.ld_addr = 0; sb.ld_maskmode = 0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_st_ready", {31'd0, sb.st_ready}, 32'd1);
    chk("rst_empty",    {31'd0, sb.sb_empty}, 32'd1);
    chk("rst_count",    {29'd0, sb.sb_count}, 32'd0);
    chk("rst_mem_write",{31'd0, sb.mem_write},32'd0);
    chk("rst_mem_read", {31'd0, sb.mem_read}, 32'd0);
    chk("rst_ld_stall", {31'd0, sb.ld_stall}, 32'd0);
    tick();

    // Single store, drained the next cycle
    do_store(32'h100, 32'hDEADBEEF, MASK_WORD, acc);
    chk("sw_accept", {31'd0, acc}, 32'd1);
    @(negedge clk);
    chk("sw_mem_write", {31'd0, sb.mem_write}, 32'd1);
    chk("sw_mem_addr",  sb.mem_address, 32'h100);
    chk("sw_mem_mask",  {30'd0, sb.mem_maskmode}, {30'd0, MASK_WORD});
    tick();
    chk("sw_empty_after", {31'd0, sb.sb_empty}, 32'd1);
    chk("sw_mem_word", rd_mem(32'h40), 32'hDEADBEEF);

    // Fill to full behind a non-matching load
    sb.ld_req = 1'b1; sb.ld_addr = 32'h200; sb.ld_maskmode = MASK_WORD;
    for (int i = 0; i < 4; i++) begin
      do_store(32'(i * 4), 32'h1111_0000 + 32'(i), MASK_WORD, acc);
      chk("fill_accept", {31'd0, acc}, 32'd1);
    end
    chk("full_count",    {29'd0, sb.sb_count}, 32'd4);
    chk("full_st_ready", {31'd0, sb.st_ready}, 32'd0);
    chk("full_mem_read", {31'd0, sb.mem_read}, 32'd1);
    chk("full_no_write", {31'd0, sb.mem_write}, 32'd0);
    do_store(32'h10, 32'h5555_5555, MASK_WORD, acc);
    chk("fifth_held", {31'd0, acc}, 32'd0);
    sb.ld_req = 1'b0;
    @(negedge clk);
    chk("drain0_addr", sb.mem_address, 32'h0);
    tick();
    @(negedge clk);
    chk("drain1_addr", sb.mem_address, 32'h4);
    tick(); tick(); tick();
    chk("full_drained", {31'd0, sb.sb_empty}, 32'd1);

    // Load hazard on a buffered byte store
    do_store(32'h101, 32'h0000_00AB, MASK_BYTE, acc);
    sb.ld_req = 1'b1; sb.ld_addr = 32'h100; sb.ld_maskmode = MASK_WORD;
    @(negedge clk);
    chk("hz_stall",     {31'd0, sb.ld_stall},  32'd1);
    chk("hz_mem_read",  {31'd0, sb.mem_read},  32'd0);
    chk("hz_mem_write", {31'd0, sb.mem_write}, 32'd1);
    tick();
    @(negedge clk);
    chk("hz_clear_stall", {31'd0, sb.ld_stall}, 32'd0);
    chk("hz_clear_read",  {31'd0, sb.mem_read}, 32'd1);
    chk("hz_load_addr",   sb.mem_address, 32'h100);
    chk("hz_mem_word",    rd_mem(32'h40), 32'hDEADABEF);
    tick();
    sb.ld_req = 1'b0;

    // Concurrent push and pop at count=2, wrapping the pointers
    sb.ld_req = 1'b1; sb.ld_addr = 32'h200;
    do_store(32'h400, 32'hA000_0000, MASK_WORD, acc);
    do_store(32'h404, 32'hA000_0001, MASK_HALF, acc);
    chk("pp_count_pre", {29'd0, sb.sb_count}, 32'd2);
    sb.ld_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_store(32'h408 + 32'(i * 4), 32'hB000_0000 + 32'(i), 2'(i % 4), acc);
      chk("pp_count", {29'd0, sb.sb_count}, 32'd2);
    end
    tick(); tick(); tick();
    chk("pp_empty", {31'd0, sb.sb_empty}, 32'd1);
    chk("pp_queue", 32'(q.size()), 32'd0);

    // Reset mid-operation discards buffered stores
    sb.ld_req = 1'b1; sb.ld_addr = 32'h200;
    do_store(32'h300, 32'hC000_0000, MASK_WORD, acc);
    do_store(32'h304, 32'hC000_0001, MASK_WORD, acc);
    do_store(32'h308, 32'hC000_0002, MASK_WORD, acc);
    chk("mid_count", {29'd0, sb.sb_count}, 32'd3);
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    sb.ld_req = 1'b0;
    chk("mid_rst_count", {29'd0, sb.sb_count}, 32'd0);
    chk("mid_rst_empty", {31'd0, sb.sb_empty}, 32'd1);
    chk("mid_rst_ready", {31'd0, sb.st_ready}, 32'd1);
    repeat (5) tick();
    chk("mid_rst_no_write", 32'(wr_disc), 32'd0);

    // Buffer resumes normally after the reset
    do_store(32'h500, 32'h1234_5678, MASK_WORD, acc);
    tick();
    chk("post_empty", {31'd0, sb.sb_empty}, 32'd1);
    chk("post_mem_word", rd_mem(32'h140), 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
